// File: rtl/thunderbird_pkg.sv
// Shared mode encoding and lamp-pattern helper for the sequential tail-light controller.
package thunderbird_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_e;

    localparam int MAX_LAMPS = 8;
    localparam int PH_MAX_W  = 4;

    // Lamp i is lit when i < phase: the inner `phase` lamps light up.
    function automatic logic [MAX_LAMPS-1:0] fill_mask(input logic [PH_MAX_W-1:0] phase, input int n);
        logic [MAX_LAMPS-1:0] m;
        m = {MAX_LAMPS{1'b0}};
        for (int i = 0; i < MAX_LAMPS; i++) begin
            m[i] = (i < int'(phase)) && (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/thunderbird_tick.sv
// Step prescaler: free-running 0..TICK_DIV-1 counter, clearable, tick on the last count.
module thunderbird_tick #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over wrap and increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/thunderbird_seq_ctrl.sv
// Sequential tail-light controller: N_LAMPS per side, left/right/hazard modes
// with priority, internal step prescaler and a brake overlay on registered lamps.
module thunderbird_seq_ctrl
    import thunderbird_pkg::*;
#(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left_req,
    input  logic               right_req,
    input  logic               haz_req,
    input  logic               brake,
    output logic               tick,
    output logic [1:0]         state_o,
    output logic [N_LAMPS-1:0] led_left,
    output logic [N_LAMPS-1:0] led_right
);

    localparam int PH_W = $clog2(N_LAMPS + 1);
    localparam logic [PH_W-1:0]    PH_ZERO = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]    PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]    PH_LAST = PH_W'(N_LAMPS);
    localparam logic [N_LAMPS-1:0] ALL_ON  = {N_LAMPS{1'b1}};
    localparam logic [N_LAMPS-1:0] ALL_OFF = {N_LAMPS{1'b0}};

    mode_e              state_q, state_d, req_s;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [N_LAMPS-1:0] led_left_q, led_left_d, led_right_q, led_right_d, fill_s;
    logic               clr_s, tick_s;

    thunderbird_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Requested mode; both turn requests together mean hazard.
    always_comb begin
        if (haz_req || (left_req && right_req)) begin
            req_s = MODE_HAZARD;
        end else if (left_req) begin
            req_s = MODE_LEFT;
        end else if (right_req) begin
            req_s = MODE_RIGHT;
        end else begin
            req_s = MODE_IDLE;
        end
    end

    // Mode/phase next state; entry from IDLE restarts the prescaler so step one is full length.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        clr_s   = 1'b0;
        case (state_q)
            MODE_IDLE: begin
                if (req_s != MODE_IDLE) begin
                    state_d = req_s;
                    phase_d = PH_ONE;
                    clr_s   = 1'b1;
                end else begin
                    state_d = MODE_IDLE;
                    phase_d = PH_ZERO;
                end
            end
            default: begin
                if (!tick_s) begin
                    state_d = state_q;
                end else if (req_s == state_q) begin
                    if (state_q == MODE_HAZARD) begin
                        phase_d = (phase_q == PH_ONE) ? PH_ZERO : PH_ONE;
                    end else if (phase_q == PH_LAST) begin
                        phase_d = PH_ZERO;
                    end else begin
                        phase_d = phase_q + PH_ONE;
                    end
                end else if (req_s != MODE_IDLE) begin
                    state_d = req_s;
                    phase_d = PH_ONE;
                end else begin
                    state_d = MODE_IDLE;
                    phase_d = PH_ZERO;
                end
            end
        endcase
    end

    assign fill_s = N_LAMPS'(fill_mask(PH_MAX_W'(phase_d), N_LAMPS));

    // Lamp patterns from the next state so the lamps track the mode register with no extra lag.
    always_comb begin
        led_left_d  = ALL_OFF;
        led_right_d = ALL_OFF;
        case (state_d)
            MODE_IDLE: begin
                led_left_d  = brake ? ALL_ON : ALL_OFF;
                led_right_d = brake ? ALL_ON : ALL_OFF;
            end
            MODE_LEFT: begin
                led_left_d  = fill_s;
                led_right_d = brake ? ALL_ON : ALL_OFF;
            end
            MODE_RIGHT: begin
                led_left_d  = brake ? ALL_ON : ALL_OFF;
                led_right_d = fill_s;
            end
            MODE_HAZARD: begin
                led_left_d  = (phase_d == PH_ONE) ? ALL_ON : ALL_OFF;
                led_right_d = (phase_d == PH_ONE) ? ALL_ON : ALL_OFF;
            end
            default: begin
                led_left_d  = ALL_OFF;
                led_right_d = ALL_OFF;
            end
        endcase
    end

    // State, phase and lamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MODE_IDLE;
            phase_q     <= PH_ZERO;
            led_left_q  <= ALL_OFF;
            led_right_q <= ALL_OFF;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            led_left_q  <= led_left_d;
            led_right_q <= led_right_d;
        end
    end

    assign tick      = tick_s;
    assign state_o   = state_q;
    assign led_left  = led_left_q;
    assign led_right = led_right_q;

endmodule

// File: tb/tb_thunderbird_seq_ctrl.sv
// Scoreboard bench for thunderbird_seq_ctrl: a 3-lamp/div-4 instance and an 8-lamp/div-2 instance.
module tb_thunderbird_seq_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] l;
        logic [7:0] r;
        logic       tk;
        logic       ck;
    } exp_t;

    localparam logic [2:0] PAT3 [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    localparam logic [7:0] PAT8 [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    logic       clk, rst;
    logic       left_req, right_req, haz_req, brake;
    logic       tick;
    logic [1:0] state_o;
    logic [2:0] led_left, led_right;
    logic       w_left, w_right, w_haz, w_brake;
    logic       w_tick;
    logic [1:0] w_state;
    logic [7:0] w_led_left, w_led_right;

    exp_t exp_q[$];
    int   total;
    int   bad;

    thunderbird_seq_ctrl #(.N_LAMPS(3), .TICK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .left_req(left_req), .right_req(right_req), .haz_req(haz_req),
        .brake(brake), .tick(tick), .state_o(state_o), .led_left(led_left), .led_right(led_right)
    );

    thunderbird_seq_ctrl #(.N_LAMPS(8), .TICK_DIV(2)) u_wide (
        .clk(clk), .rst(rst), .left_req(w_left), .right_req(w_right), .haz_req(w_haz),
        .brake(w_brake), .tick(w_tick), .state_o(w_state), .led_left(w_led_left), .led_right(w_led_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] st, input logic [7:0] l, input logic [7:0] r,
                                input logic tk, input logic ck);
        exp_t e;
        e.st = st; e.l = l; e.r = r; e.tk = tk; e.ck = ck;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
        exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                bad++;
                $display("FAIL reset k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
            end
            if (k == 1) begin
                rst = 1'b0;
                brake = 1'b0;
                for (int j = 2; j < 6; j++) exp_q.push_back(mk(2'b00, 8'h00, 8'h00, j == 4, 1'b1));
            end
        end
    endtask

    task automatic test_left();
        exp_t e;
        left_req = 1'b1;
        for (int k = 0; k < 20; k++) exp_q.push_back(mk(2'b01, 8'(PAT3[(k / 4) % 4]), 8'h00, (k % 4) == 3, 1'b1));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                bad++;
                $display("FAIL left k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
            end
            if (k == 19) begin
                left_req = 1'b0;
                exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_hazard();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                left_req = 1'b1;
                right_req = 1'b1;
            end else begin
                haz_req = 1'b1;
            end
            for (int k = 0; k < 16; k++) begin
                exp_q.push_back(mk(2'b11, ((k / 4) % 2 == 0) ? 8'h07 : 8'h00,
                                   ((k / 4) % 2 == 0) ? 8'h07 : 8'h00, (k % 4) == 3, 1'b1));
            end
            for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                total++;
                if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                    bad++;
                    $display("FAIL hazard p=%0d k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                             pass, k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
                end
                if (k == 15) begin
                    left_req = 1'b0;
                    right_req = 1'b0;
                    haz_req = 1'b0;
                    exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
                end
            end
        end
    endtask

    task automatic test_brake();
        exp_t e;
        brake = 1'b1;
        exp_q.push_back(mk(2'b00, 8'h07, 8'h07, 1'b0, 1'b0));
        exp_q.push_back(mk(2'b00, 8'h07, 8'h07, 1'b0, 1'b0));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                bad++;
                $display("FAIL brake k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
            end
            if (k == 1) begin
                right_req = 1'b1;
                for (int j = 2; j < 18; j++) begin
                    exp_q.push_back(mk(2'b10, 8'h07, 8'(PAT3[((j - 2) / 4) % 4]), ((j - 2) % 4) == 3, 1'b1));
                end
            end
            if (k == 17) begin
                right_req = 1'b0;
                exp_q.push_back(mk(2'b00, 8'h07, 8'h07, 1'b0, 1'b1));
            end
            if (k == 18) begin
                brake = 1'b0;
                exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_mode_change();
        exp_t e;
        left_req = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(2'b01, 8'(PAT3[k / 4]), 8'h00, (k % 4) == 3, 1'b1));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                bad++;
                $display("FAIL mode_change k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
            end
            if (k == 5) begin
                left_req = 1'b0;
                right_req = 1'b1;
                for (int j = 8; j < 16; j++) begin
                    exp_q.push_back(mk(2'b10, 8'h00, (j < 12) ? 8'h01 : 8'h03, (j % 4) == 3, 1'b1));
                end
            end
            if (k == 13) begin
                right_req = 1'b0;
                exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
                exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        left_req = 1'b1;
        for (int k = 0; k < 10; k++) exp_q.push_back(mk(2'b01, 8'(PAT3[k / 4]), 8'h00, (k % 4) == 3, 1'b1));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                bad++;
                $display("FAIL async_rst k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
            end
        end
        #2;
        rst = 1'b1;
        exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
        #1;
        e = exp_q.pop_front();
        total++;
        if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
            bad++;
            $display("FAIL async_rst_now got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                     state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
        end
        exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (state_o !== e.st || {5'b0, led_left} !== e.l || {5'b0, led_right} !== e.r || (e.ck && tick !== e.tk)) begin
                bad++;
                $display("FAIL async_rst_after k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, state_o, led_left, led_right, tick, e.st, e.l[2:0], e.r[2:0], e.tk);
            end
            if (k == 0) begin
                rst = 1'b0;
                for (int j = 1; j < 5; j++) exp_q.push_back(mk(2'b01, 8'h01, 8'h00, j == 4, 1'b1));
            end
            if (k == 4) begin
                left_req = 1'b0;
                exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_wide();
        exp_t e;
        w_left = 1'b1;
        for (int k = 0; k < 20; k++) exp_q.push_back(mk(2'b01, PAT8[(k / 2) % 9], 8'h00, (k % 2) == 1, 1'b1));
        for (int k = 0; exp_q.size() > 0 && k < 100; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (w_state !== e.st || w_led_left !== e.l || w_led_right !== e.r || (e.ck && w_tick !== e.tk)) begin
                bad++;
                $display("FAIL wide k=%0d got st=%b l=%b r=%b tk=%b want st=%b l=%b r=%b tk=%b",
                         k, w_state, w_led_left, w_led_right, w_tick, e.st, e.l, e.r, e.tk);
            end
            if (k == 19) begin
                w_left = 1'b0;
                exp_q.push_back(mk(2'b00, 8'h00, 8'h00, 1'b0, 1'b1));
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        left_req = 1'b0;
        right_req = 1'b0;
        haz_req = 1'b0;
        brake = 1'b1;
        w_left = 1'b0;
        w_right = 1'b0;
        w_haz = 1'b0;
        w_brake = 1'b0;
        test_reset();
        test_left();
        test_hazard();
        test_brake();
        test_mode_change();
        test_async_reset();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thunderbird_seq_ctrl.md
Name: thunderbird_seq_ctrl

Overview:
Parametrised successor to the fixed 3+3 tail-light wrapper. A single controller drives N_LAMPS sequential lamps per side. It has an internal step prescaler, left/right/hazard modes with priority, and a brake overlay. It sits between the board switch inputs and the LED outputs, and replaces the separate divider plus per-side FSM instances.

Parameters:
N_LAMPS, 3, lamps per side (legal 2..8); bit 0 is innermost.
TICK_DIV, 25_000_000, clk cycles per sequence step (legal >= 2).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
left_req  input  1  left turn request; level, synchronous to clk.
right_req  input  1  right turn request; level.
haz_req  input  1  hazard request; level.
brake  input  1  brake pedal; level.
tick  output  1  one-cycle step pulse (debug/cascade).
state_o  output  2  mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.
led_left  output  N_LAMPS  left lamps; registered.
led_right  output  N_LAMPS  right lamps; registered.

Behaviour:
- Reset (async, rst=1): state IDLE, phase 0, prescaler 0, tick 0, led_left/led_right all 0. Lamps stay off while rst=1, even with brake=1.
- Requested mode, evaluated every cycle:
  - HAZARD if haz_req=1, or if left_req=1 and right_req=1.
  - Otherwise LEFT if left_req=1.
  - Otherwise RIGHT if right_req=1.
  - Otherwise IDLE.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 exactly when count==TICK_DIV-1.
- From IDLE with requested mode != IDLE, at the sampling edge:
  - state <= requested mode, phase <= 1.
  - Prescaler is cleared to 0, so the first step lasts exactly TICK_DIV cycles.
  - LEDs show phase 1 from that same edge (zero extra latency beyond the register).
- In LEFT/RIGHT/HAZARD, changes happen only on tick edges:
  - Requested mode == current mode: phase advances.
  - Requested mode differs, non-IDLE: switch to that mode, phase <= 1.
  - Requested mode is IDLE: state <= IDLE, phase <= 0, lamps off (brake overlay still applies).
  - Between ticks, request changes are ignored.
- Phase rules:
  - LEFT/RIGHT: phase runs 0..N_LAMPS, then wraps N_LAMPS -> 0. The sequencing side shows the low `phase` bits set, i.e. (1<<phase)-1. Phase 0 means all off.
  - HAZARD: phase toggles 1 <-> 0. Both sides all-ones on phase 1, all-zero on phase 0.
- Brake overlay, applied when computing the registered LEDs:
  - IDLE: both sides all-ones.
  - LEFT: led_right all-ones; led_left still sequences.
  - RIGHT: mirror of LEFT.
  - HAZARD: brake is ignored.
  - A brake change is visible on the LEDs one clk later.
- Width rules: phase is clog2(N_LAMPS+1) bits. The prescaler is clog2(TICK_DIV) bits. No truncation is allowed at N_LAMPS=8.
- Simultaneous events:
  - A tick coinciding with an IDLE->active entry is irrelevant, because the prescaler is cleared.
  - Reset asserted mid-sequence aborts immediately, asynchronously.
  - After reset release, the first active request behaves as an entry from IDLE.
- state_o is a direct register output.

Decomposition:
- Package thunderbird_pkg: mode encoding constants MODE_IDLE/LEFT/RIGHT/HAZARD (2-bit), and a lamp-pattern function fill_mask(phase, N).
- Sub-module thunderbird_tick: prescaler with parameter TICK_DIV; inputs clk, rst, clr; output tick.
- The FSM, phase counter and LED registers stay in the top.

Test Plan:
(All with N_LAMPS=3, TICK_DIV=4.)
1. left_req=1 held from edge E:
   - state_o=01, led_left=001 after E; 011 after E+4; 111 after E+8; 000 after E+12; 001 after E+16.
   - led_right=000 throughout.
2. left_req=1 and right_req=1 at the same time:
   - state_o=11; both sides 111 for 4 cycles, then 000 for 4, alternating.
   - haz_req alone gives the identical result.
3. brake=1 with no request:
   - Both sides 111 one clk later.
   - Then assert right_req: led_left stays 111 while led_right runs 001/011/111/000.
4. Mode change mid-sequence:
   - Start LEFT, reach led_left=011, then switch to right_req only.
   - At the next tick: state_o=10, led_right=001, led_left=000.
   - Releasing all requests returns to IDLE, all 0, only on a tick.
5. Assert rst asynchronously at led_left=111 (between clk edges):
   - All outputs 0 immediately, state_o=00.
   - After release with left_req held: 001 on the first edge.
6. N_LAMPS=8, TICK_DIV=2, LEFT:
   - Sequence 00000001 .. 11111111, then 00000000, 9 steps of 2 cycles each.
   - tick pulses every 2nd cycle.
